uart_mmio_fifo: RTL and testbench
=================================

Name: uart_mmio_fifo

Overview:
Next-generation memory-mapped serial peripheral for the ARC softcore system. It replaces the fixed-rate, unbuffered peripheral block with an 8N1 UART that has a run-time programmable baud divisor, parametrised-depth TX and RX FIFOs, sticky error flags and an interrupt output. It sits on the MM/IO bus: the top level decodes the IO window into `sel`, passes the word index on `addr`, and muxes `data_out` onto the datapath read bus.

Parameters:
- DATA_W, 32, CPU bus width; bytes occupy bits [7:0], upper bits read as zero and are ignored on write.
- FIFO_DEPTH, 16, entries per FIFO; power of two, minimum 2.
- DEFAULT_DIV, 26, reset value of BAUD; one oversample tick every DEFAULT_DIV+1 clocks (16 ticks per bit).

Ports:
- clk, in, 1: single system clock.
- rst, in, 1: asynchronous, active-high reset.
- sel, in, 1: IO window select.
- rd, in, 1: read strobe, one access per cycle.
- wr, in, 1: write strobe, one access per cycle.
- addr, in, 2: register index.
- data_in, in, DATA_W: write data.
- data_out, out, DATA_W: read data, combinational.
- rx, in, 1: serial input, asynchronous.
- tx, out, 1: serial output, idle high.
- irq, out, 1: interrupt request, registered.

Behaviour:
- Accesses:
  - Access occurs only when sel=1. rd and wr both high: wr wins, no pop.
  - Every clock with the strobe high is a separate access (a strobe held 2 cycles pops twice).
- Register map:
  - addr 0 DATA: write pushes data_in[7:0] into the TX FIFO. Read returns the RX FIFO head, then pops it at the clock edge.
  - addr 1 STATUS (RO): [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_ovr, [5] frame_err, [6] tx_ovf, [7] tx_busy.
  - addr 2 BAUD: RW, 16 bits, reset value DEFAULT_DIV.
  - addr 3 CTRL: [0] rx_irq_en, [1] tx_irq_en (RW). Writing 1 to [2] clears rx_ovr, frame_err and tx_ovf (self-clearing, reads 0).
- data_out is 0 when sel=0 or rd=0. Read of DATA with RX empty returns 0 and the pointers do not move.
- Write to DATA with TX full: data dropped, tx_ovf set.
- FIFOs:
  - Binary read/write pointers plus a count of width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop is legal in any state, including full and empty-with-push. Full+push+pop: both occur, count unchanged. Empty: pop suppressed.
- Baud tick:
  - Counter 0..BAUD; tick is a one-clock pulse when counter==BAUD, then the counter clears.
  - A write to BAUD clears the counter.
  - BAUD=0 gives a tick every clock.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: pops a byte on the cycle tx FIFO is non-empty; tx_busy=1 from that cycle until STOP completes.
  - Each bit lasts 16 ticks. Data is sent LSB first, 8 bits. Stop bit is 1.
  - tx is registered and high in IDLE.
  - Back-to-back bytes: IDLE is held for exactly one clock between frames.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - rx passes through a 2-flop synchronizer.
  - START: a falling edge starts it; at tick 7 rx is re-checked. Still low: go to DATA. High: glitch, return to IDLE.
  - DATA: each bit is sampled at the 16th tick after the previous sample point (bit centre).
  - STOP: sample taken. If it is 0, frame_err is set and the byte is discarded. Otherwise the byte is pushed.
  - Push while RX full (and no same-cycle pop): byte dropped, rx_ovr set.
- irq: registered, = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty) | rx_ovr | frame_err.
- Reset values:
  - FIFOs empty, both FSMs IDLE, tx=1, irq=0, CTRL=0, flags=0, BAUD=DEFAULT_DIV, data_out=0.
  - Reset mid-frame: the frame is abandoned immediately and tx returns high asynchronously.

Test Plan:
1. Reset, then read STATUS -> 0x05 (rx_empty, tx_empty); BAUD reads 26; tx=1, irq=0.
2. BAUD=0, write DATA 0xA5 -> tx low 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then high 16 clk; tx_busy=1 for 160 clk; STATUS[2]=1 after pop.
3. Loop tx to rx, BAUD=0, write 0x3C, 0xC3 -> after both frames STATUS[0]=0; DATA reads return 0x3C then 0xC3, then 0 with rx_empty=1.
4. FIFO_DEPTH=4: write 6 bytes while TX idle-stalled (hold rst of far end; serialiser pops 1) -> 5 accepted, STATUS[6]=1; CTRL write 0x4 -> STATUS[6]=0.
5. Drive rx with 5 frames, no reads, FIFO_DEPTH=4 -> rx_full=1, rx_ovr=1, irq=1; first read returns frame 1; simultaneous push+pop at full keeps count 4.
6. Drive rx with stop bit 0 -> frame_err=1, nothing pushed; a 3-clock low glitch (BAUD=0) -> no frame, RX back to IDLE; assert rst mid-TX frame -> tx=1 same cycle, FIFOs empty.

Source files
------------

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped 8N1 UART with programmable baud divisor, TX/RX FIFOs,
// sticky error flags and a registered interrupt.
module uart_mmio_fifo #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rd,
  input  logic              wr,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              rx,
  output logic              tx,
  output logic              irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Bus decode; a write in the same cycle as a read suppresses the pop.
  logic acc_wr, acc_rd, wr_data, wr_baud, wr_ctrl, rd_data;
  assign acc_wr  = sel & wr;
  assign acc_rd  = sel & rd & ~wr;
  assign wr_data = acc_wr & (addr == 2'd0);
  assign wr_baud = acc_wr & (addr == 2'd2);
  assign wr_ctrl = acc_wr & (addr == 2'd3);
  assign rd_data = acc_rd & (addr == 2'd0);

  logic unused_data;
  assign unused_data = ^data_in[DATA_W-1:16];

  logic [15:0] baud, baud_cnt;
  logic [1:0]  ctrl;
  logic        rx_ovr, frame_err, tx_ovf;
  logic        tick;

  assign tick = (baud_cnt == baud);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud     <= 16'(DEFAULT_DIV);
      baud_cnt <= '0;
      ctrl     <= '0;
    end else begin
      if (wr_baud) baud <= data_in[15:0];
      if (wr_ctrl) ctrl <= data_in[1:0];
      if (wr_baud || tick) baud_cnt <= '0;
      else                 baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_empty, tx_full, tx_pop, tx_do_push;
  tx_state_e     tx_state;

  assign tx_empty   = (tx_cnt == '0);
  assign tx_full    = (tx_cnt == FULL_CNT);
  assign tx_pop     = (tx_state == TxIdle) & ~tx_empty;
  assign tx_do_push = wr_data & (~tx_full | tx_pop);

  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wp] <= data_in[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_do_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)     tx_rp <= tx_rp + AW'(1);
      case ({tx_do_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX serialiser: 16 ticks per bit, LSB first
  logic [7:0] tx_sh;
  logic [3:0] tx_tcnt;
  logic [2:0] tx_bit;
  logic       tx_busy;

  assign tx_busy = (tx_state != TxIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TxIdle;
      tx       <= 1'b1;
      tx_sh    <= '0;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
    end else begin
      unique case (tx_state)
        TxIdle: begin
          if (!tx_empty) begin
            tx_sh    <= tx_mem[tx_rp];
            tx       <= 1'b0;
            tx_tcnt  <= '0;
            tx_state <= TxStart;
          end
        end
        TxStart: begin
          if (tick) begin
            tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
              tx       <= tx_sh[0];
              tx_bit   <= '0;
              tx_state <= TxData;
            end
          end
        end
        TxData: begin
          if (tick) begin
            tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
              if (tx_bit == 3'd7) begin
                tx       <= 1'b1;
                tx_state <= TxStop;
              end else begin
                tx     <= tx_sh[1];
                tx_sh  <= {1'b0, tx_sh[7:1]};
                tx_bit <= tx_bit + 3'd1;
              end
            end
          end
        end
        TxStop: begin
          if (tick) begin
            tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) tx_state <= TxIdle;
          end
        end
      endcase
    end
  end

  // RX synchroniser and deserialiser
  logic       rx_s1, rx_s2, rx_prev, rx_fall;
  rx_state_e  rx_state;
  logic [7:0] rx_sh;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bit;
  logic       rx_stop_smp, rx_push;

  assign rx_fall     = rx_prev & ~rx_s2;
  assign rx_stop_smp = (rx_state == RxStop) & tick & (rx_tcnt == 4'd15);
  assign rx_push     = rx_stop_smp & rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RxIdle;
      rx_sh    <= '0;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      unique case (rx_state)
        RxIdle: begin
          if (rx_fall) begin
            rx_tcnt  <= '0;
            rx_state <= RxStart;
          end
        end
        RxStart: begin
          if (tick) begin
            if (rx_tcnt == 4'd7) begin
              rx_tcnt  <= '0;
              rx_bit   <= '0;
              rx_state <= rx_s2 ? RxIdle : RxData;
            end else begin
              rx_tcnt <= rx_tcnt + 4'd1;
            end
          end
        end
        RxData: begin
          if (tick) begin
            rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_tcnt == 4'd15) begin
              rx_sh  <= {rx_s2, rx_sh[7:1]};
              rx_bit <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) rx_state <= RxStop;
            end
          end
        end
        RxStop: begin
          if (tick) begin
            rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_tcnt == 4'd15) rx_state <= RxIdle;
          end
        end
      endcase
    end
  end

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_empty, rx_full, rx_pop, rx_do_push;

  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == FULL_CNT);
  assign rx_pop     = rd_data & ~rx_empty;
  assign rx_do_push = rx_push & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (rx_do_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_do_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)     rx_rp <= rx_rp + AW'(1);
      case ({rx_do_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins
  logic flag_clr;
  assign flag_clr = wr_ctrl & data_in[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      rx_ovr    <= (rx_ovr & ~flag_clr) | (rx_push & rx_full & ~rx_pop);
      frame_err <= (frame_err & ~flag_clr) | (rx_stop_smp & ~rx_s2);
      tx_ovf    <= (tx_ovf & ~flag_clr) | (wr_data & tx_full & ~tx_pop);
      irq       <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty) | rx_ovr | frame_err;
    end
  end

  logic [7:0] status;
  assign status = {tx_busy, tx_ovf, frame_err, rx_ovr, tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    data_out = '0;
    if (sel && rd) begin
      unique case (addr)
        2'd0: if (!rx_empty) data_out[7:0] = rx_mem[rx_rp];
        2'd1: data_out[7:0]  = status;
        2'd2: data_out[15:0] = baud;
        2'd3: data_out[1:0]  = ctrl;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo (FIFO_DEPTH=4): register map, TX waveform,
// loopback, FIFO overflow, RX overrun, framing error, glitch reject, reset.
module tb_uart_mmio_fifo;

  logic        clk = 1'b0;
  logic        rst, sel, rd, wr;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  logic        tx, irq, rx_drv, loop_en, rx_line;
  int          n_pass = 0;
  int          n_total = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_mmio_fifo #(
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .DEFAULT_DIV(26)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .rx      (rx_line),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // All bus tasks start and end 1 time unit after a rising edge
  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0; data_in = '0;
  endtask

  task automatic rreg(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk); d = data_out;
    @(posedge clk); #1;
    sel = 1'b0; rd = 1'b0;
  endtask

  // 16 clocks per bit, valid only with BAUD=0
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      rx_drv = 1'b0;
      else if (j == 9) rx_drv = stop_bit;
      else             rx_drv = b[j-1];
      repeat (16) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  pat;
    logic        exp_tx;
    int          tx_bad, busy_n;

    rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: reset state
    rreg(2'd1, v); check("reset_status", v, 32'h05);
    rreg(2'd2, v); check("reset_baud", v, 32'd26);
    rreg(2'd3, v); check("reset_ctrl", v, 32'd0);
    rd = 1'b1; addr = 2'd1; #1;
    check("dout_nosel", data_out, 32'd0);
    rd = 1'b0;
    rreg(2'd0, v); check("read_empty_rx", v, 32'd0);

    // 2: single frame 0xA5 at BAUD=0
    wreg(2'd2, 32'd0);
    rreg(2'd2, v); check("baud_rw", v, 32'd0);
    pat = 8'hA5;
    wreg(2'd0, 32'h1234_56A5);
    tx_bad = 0; busy_n = 0;
    sel = 1'b1; rd = 1'b1; addr = 2'd1;
    for (int i = 0; i < 170; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 16)       exp_tx = 1'b0;
      else if (i < 144) exp_tx = pat[(i-16)/16];
      else              exp_tx = 1'b1;
      if (tx !== exp_tx) tx_bad++;
      if (data_out[7]) busy_n++;
      if (i == 0) check("tx_empty_after_pop", data_out[2], 1'b1);
    end
    sel = 1'b0; rd = 1'b0;
    check("tx_wave_a5", tx_bad, 0);
    check("tx_busy_cycles", busy_n, 160);
    rreg(2'd1, v); check("status_after_tx", v, 32'h05);

    // 3: loopback of two back-to-back bytes
    loop_en = 1'b1;
    wreg(2'd0, 32'h3C);
    wreg(2'd0, 32'hC3);
    repeat (400) @(posedge clk);
    #1;
    rreg(2'd1, v); check("loop_status", v, 32'h04);
    rreg(2'd0, v); check("loop_byte0", v, 32'h3C);
    rreg(2'd0, v); check("loop_byte1", v, 32'hC3);
    rreg(2'd0, v); check("loop_empty_read", v, 32'd0);
    rreg(2'd1, v); check("loop_status_end", v, 32'h05);
    loop_en = 1'b0;

    // 4: TX overflow: 6 writes, 1 popped, 4 stored, 1 dropped
    for (int k = 1; k <= 6; k++) wreg(2'd0, k);
    rreg(2'd1, v); check("tx_ovf_status", v, 32'hC9);
    wreg(2'd3, 32'h4);
    rreg(2'd1, v); check("tx_ovf_cleared", v, 32'h89);
    repeat (830) @(posedge clk);
    #1;
    rreg(2'd1, v); check("tx_drained", v, 32'h05);
    wreg(2'd3, 32'h2);
    repeat (2) @(posedge clk);
    @(negedge clk); check("irq_tx_empty", irq, 1'b1);
    wreg(2'd3, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); check("irq_off", irq, 1'b0);
    @(posedge clk); #1;

    // 5: RX overrun with five frames into a 4-deep FIFO
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
    rreg(2'd1, v); check("rx_ovr_status", v, 32'h16);
    @(negedge clk); check("irq_rx_ovr", irq, 1'b1);
    @(posedge clk); #1;
    rreg(2'd0, v); check("rx_first_frame", v, 32'h11);
    wreg(2'd3, 32'h4);
    send_frame(8'h66, 1'b1);
    rreg(2'd1, v); check("rx_full_again", v, 32'h06);
    // Stop-bit push of the next frame lands on edge 155; pop on the same edge
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        sel = 1'b1; rd = 1'b1; addr = 2'd0;
        @(negedge clk); v = data_out;
        @(posedge clk); #1;
        sel = 1'b0; rd = 1'b0;
      end
    join
    check("push_pop_full_read", v, 32'h22);
    rreg(2'd1, v); check("push_pop_full_status", v, 32'h06);
    rreg(2'd0, v); check("rx_drain0", v, 32'h33);
    rreg(2'd0, v); check("rx_drain1", v, 32'h44);
    rreg(2'd0, v); check("rx_drain2", v, 32'h66);
    rreg(2'd0, v); check("rx_drain3", v, 32'h77);
    rreg(2'd1, v); check("rx_drained", v, 32'h05);

    // 6: framing error, glitch reject, reset mid-frame
    send_frame(8'h5A, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rreg(2'd1, v); check("frame_err_status", v, 32'h25);
    @(negedge clk); check("irq_frame_err", irq, 1'b1);
    @(posedge clk); #1;
    wreg(2'd3, 32'h4);
    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rreg(2'd1, v); check("glitch_status", v, 32'h05);
    send_frame(8'h5A, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rreg(2'd0, v); check("after_glitch_frame", v, 32'h5A);

    wreg(2'd0, 32'h00);
    wreg(2'd0, 32'h12);
    repeat (40) @(posedge clk);
    @(negedge clk); check("tx_mid_frame_low", tx, 1'b0);
    rst = 1'b1;
    #1; check("tx_async_reset", tx, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rreg(2'd1, v); check("status_after_rst", v, 32'h05);
    rreg(2'd2, v); check("baud_after_rst", v, 32'd26);
    @(negedge clk); check("tx_idle_after_rst", tx, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
